// File: rtl/dram_block_unpacker.sv
// Fetches DRAMW-bit blocks from DRAM in bursts, buffers them in a block FIFO and
// unpacks each block into WAYS-element beats on a valid/ready stream.
//
// state | meaning
// IDLE  | waiting for START
// ISSUE | request next burst once the DRAM is free and the FIFO has room for it
// WAIT  | collecting the blocks of the outstanding burst
// DRAIN | all blocks fetched; wait for the FIFO to empty, then pulse DONE
module dram_block_unpacker #(
   parameter int          DRAMW     = 512,
   parameter int          ELEMW     = 32,
   parameter int          WAYS      = 4,
   parameter int          BURST     = 4,
   parameter int          FIFO_LOG  = 3,
   parameter int          ADDR_STEP = 8,
   parameter logic [31:0] LAST_ADDR = 32'h07FFFFF8,
   parameter logic [1:0]  REQ_READ  = 2'd2
) (
   input  logic                  CLK,
   input  logic                  RST_X,
   input  logic                  START,
   input  logic [31:0]           BASE_ADR,
   input  logic [31:0]           NBLOCKS,
   output logic [1:0]            D_REQ,
   output logic [31:0]           D_INITADR,
   output logic [31:0]           D_BLOCKS,
   input  logic                  D_BUSY,
   input  logic [DRAMW-1:0]      D_DOUT,
   input  logic                  D_DOUTEN,
   output logic [WAYS*ELEMW-1:0] O_DATA,
   output logic                  O_VALID,
   input  logic                  O_READY,
   output logic                  BUSY,
   output logic                  DONE,
   output logic                  ERR
);

   localparam int          BW        = WAYS * ELEMW;
   localparam int          BPB       = DRAMW / BW;
   localparam int          DEPTH     = 1 << FIFO_LOG;
   localparam int          GW        = $clog2(BURST + 1);
   localparam int          KW        = (BPB > 1) ? $clog2(BPB) : 1;
   localparam logic [31:0] WRAP_SPAN = LAST_ADDR + 32'(ADDR_STEP);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

   state_t              state;
   logic [31:0]         adr;
   logic [31:0]         rem;
   logic [GW-1:0]       got;
   logic [GW-1:0]       blen_q;
   logic [FIFO_LOG:0]   fifo_count;
   logic [FIFO_LOG-1:0] wr_ptr;
   logic [FIFO_LOG-1:0] rd_ptr;
   logic [KW-1:0]       k;
   logic [DRAMW-1:0]    mem [DEPTH];
   logic [DRAMW-1:0]    head;

   logic                fifo_full;
   logic                fifo_empty;
   logic                push;
   logic                xfer;
   logic                pop;
   logic [31:0]         blen_w;
   logic                can_issue;
   logic                last_blk;
   logic [31:0]         adr_sum;
   logic [31:0]         adr_next;

   assign fifo_full  = (fifo_count == (FIFO_LOG+1)'(DEPTH));
   assign fifo_empty = (fifo_count == '0);
   assign push       = D_DOUTEN && (state == S_WAIT) && !fifo_full;
   assign xfer       = !fifo_empty && O_READY;
   assign pop        = xfer && (k == KW'(BPB - 1));

   assign blen_w    = (rem < 32'(BURST)) ? rem : 32'(BURST);
   assign can_issue = !D_BUSY && (32'(fifo_count) <= 32'(DEPTH) - blen_w);
   assign last_blk  = D_DOUTEN && ((got + GW'(1)) == blen_q);

   // Blocks are aligned, so crossing LAST_ADDR folds back by exactly one span.
   assign adr_sum  = adr + 32'(blen_q) * 32'(ADDR_STEP);
   assign adr_next = (adr_sum > LAST_ADDR) ? (adr_sum - WRAP_SPAN) : adr_sum;

   assign head    = mem[rd_ptr];
   assign O_VALID = !fifo_empty;
   assign O_DATA  = fifo_empty ? '0 : head[k*BW +: BW];

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         state     <= S_IDLE;
         adr       <= '0;
         rem       <= '0;
         got       <= '0;
         blen_q    <= '0;
         D_REQ     <= 2'd0;
         D_INITADR <= '0;
         D_BLOCKS  <= '0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         ERR       <= 1'b0;
      end else begin
         D_REQ <= 2'd0;
         DONE  <= 1'b0;
         if (START && BUSY)
            ERR <= 1'b1;
         if (D_DOUTEN && ((state != S_WAIT) || fifo_full))
            ERR <= 1'b1;
         case (state)
            S_IDLE: begin
               if (START) begin
                  adr   <= BASE_ADR;
                  rem   <= NBLOCKS;
                  BUSY  <= 1'b1;
                  state <= (NBLOCKS == '0) ? S_DRAIN : S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (can_issue) begin
                  D_REQ     <= REQ_READ;
                  D_INITADR <= adr;
                  D_BLOCKS  <= blen_w;
                  blen_q    <= GW'(blen_w);
                  got       <= '0;
                  state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               // A dropped (overflowing) block still counts toward the burst.
               if (D_DOUTEN)
                  got <= got + GW'(1);
               if (last_blk) begin
                  rem   <= rem - 32'(blen_q);
                  adr   <= adr_next;
                  state <= (rem != 32'(blen_q)) ? S_ISSUE : S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (fifo_empty) begin
                  DONE  <= 1'b1;
                  BUSY  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         k          <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + FIFO_LOG'(1);
         if (pop)
            rd_ptr <= rd_ptr + FIFO_LOG'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + (FIFO_LOG+1)'(1);
            2'b01:   fifo_count <= fifo_count - (FIFO_LOG+1)'(1);
            default: fifo_count <= fifo_count;
         endcase
         if (xfer)
            k <= pop ? '0 : k + KW'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (push)
         mem[wr_ptr] <= D_DOUT;
   end

endmodule

// File: tb/tb_dram_block_unpacker.sv
// Directed bench for dram_block_unpacker: behavioural DRAM responder, beat scoreboard
// built from the expected block address sequence, and request log checks.
module tb_dram_block_unpacker;

   localparam logic [31:0] LAST = 32'h07FFFFF8;

   logic         CLK = 1'b0;
   logic         RST_X;
   logic         START;
   logic [31:0]  BASE_ADR;
   logic [31:0]  NBLOCKS;
   logic [1:0]   D_REQ;
   logic [31:0]  D_INITADR;
   logic [31:0]  D_BLOCKS;
   logic         D_BUSY;
   logic [511:0] D_DOUT = '0;
   logic         D_DOUTEN;
   logic [127:0] O_DATA;
   logic         O_VALID;
   logic         O_READY;
   logic         BUSY;
   logic         DONE;
   logic         ERR;

   logic         dram_en = 1'b0;
   logic         inj_en  = 1'b0;
   assign D_DOUTEN = dram_en | inj_en;

   int           n_checks = 0;
   int           n_fail   = 0;
   int           beats_seen = 0;
   int           done_cnt   = 0;
   logic [31:0]  dq[$];
   logic [127:0] exp_q[$];
   logic [31:0]  req_a[$];
   logic [31:0]  req_n[$];

   dram_block_unpacker dut (
      .CLK(CLK), .RST_X(RST_X), .START(START), .BASE_ADR(BASE_ADR), .NBLOCKS(NBLOCKS),
      .D_REQ(D_REQ), .D_INITADR(D_INITADR), .D_BLOCKS(D_BLOCKS), .D_BUSY(D_BUSY),
      .D_DOUT(D_DOUT), .D_DOUTEN(D_DOUTEN), .O_DATA(O_DATA), .O_VALID(O_VALID),
      .O_READY(O_READY), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] next_adr(input logic [31:0] a);
      return (a == LAST) ? 32'h0 : a + 32'd8;
   endfunction

   // Element j of the block at address a holds a*2 + j, so values run in address order.
   function automatic logic [511:0] blk(input logic [31:0] a);
      logic [511:0] d;
      for (int j = 0; j < 16; j++) d[j*32 +: 32] = a * 32'd2 + 32'(j);
      return d;
   endfunction

   function automatic logic [127:0] beat(input logic [31:0] a, input int b);
      logic [127:0] v;
      for (int e = 0; e < 4; e++) v[e*32 +: 32] = a * 32'd2 + 32'(b * 4 + e);
      return v;
   endfunction

   function automatic logic [31:0] req_adr_at(input int i);
      return (i < req_a.size()) ? req_a[i] : 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] req_n_at(input int i);
      return (i < req_n.size()) ? req_n[i] : 32'hFFFF_FFFF;
   endfunction

   task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // DRAM model: data for a request starts the cycle after D_REQ, one block per cycle.
   always @(negedge CLK) begin : dram_model
      logic [31:0] ad;
      if (dq.size() > 0) begin
         D_DOUT  = blk(dq.pop_front());
         dram_en = 1'b1;
      end else begin
         dram_en = 1'b0;
      end
      if (RST_X && D_REQ == 2'd2) begin
         req_a.push_back(D_INITADR);
         req_n.push_back(D_BLOCKS);
         ad = D_INITADR;
         for (int i = 0; i < int'(D_BLOCKS); i++) begin
            dq.push_back(ad);
            ad = next_adr(ad);
         end
      end
   end

   always @(negedge CLK) begin
      if (DONE) done_cnt++;
      if (RST_X && O_VALID && O_READY) begin
         beats_seen++;
         if (exp_q.size() > 0) check_val("beat", O_DATA, exp_q.pop_front());
      end
   end

   task automatic new_test(input logic [31:0] base, input logic [31:0] n);
      logic [31:0] a;
      req_a.delete();
      req_n.delete();
      exp_q.delete();
      beats_seen = 0;
      done_cnt   = 0;
      a = base;
      for (int i = 0; i < int'(n); i++) begin
         for (int b = 0; b < 4; b++) exp_q.push_back(beat(a, b));
         a = next_adr(a);
      end
   endtask

   task automatic do_start(input logic [31:0] base, input logic [31:0] n);
      @(negedge CLK);
      START = 1'b1;
      BASE_ADR = base;
      NBLOCKS = n;
      @(negedge CLK);
      START = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int c = 0;
      while (done_cnt == 0 && c < budget) begin
         @(negedge CLK);
         c++;
      end
      check_val("done_seen", 128'(done_cnt != 0), 128'(1));
      repeat (3) @(negedge CLK);
      check_val("done_once", 128'(done_cnt), 128'(1));
      check_val("busy_after_done", 128'(BUSY), 128'(0));
   endtask

   task automatic check_req(input int i, input logic [31:0] a, input logic [31:0] n);
      check_val($sformatf("req%0d_adr", i), 128'(req_adr_at(i)), 128'(a));
      check_val($sformatf("req%0d_blocks", i), 128'(req_n_at(i)), 128'(n));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      RST_X = 1'b0; START = 1'b0; BASE_ADR = '0; NBLOCKS = '0;
      D_BUSY = 1'b0; O_READY = 1'b1;
      repeat (3) @(negedge CLK);
      check_val("rst_d_req", 128'(D_REQ), 128'(0));
      check_val("rst_d_initadr", 128'(D_INITADR), 128'(0));
      check_val("rst_d_blocks", 128'(D_BLOCKS), 128'(0));
      check_val("rst_o_valid", 128'(O_VALID), 128'(0));
      check_val("rst_o_data", O_DATA, 128'(0));
      check_val("rst_busy_done_err", 128'({BUSY, DONE, ERR}), 128'(0));
      RST_X = 1'b1;

      // Normal 10-block fetch.
      new_test(32'h100, 32'd10);
      do_start(32'h100, 32'd10);
      wait_done(400);
      check_val("t1_nreq", 128'(req_a.size()), 128'(3));
      check_req(0, 32'h100, 32'd4);
      check_req(1, 32'h120, 32'd4);
      check_req(2, 32'h140, 32'd2);
      check_val("t1_beats", 128'(beats_seen), 128'(40));
      check_val("t1_err", 128'(ERR), 128'(0));

      // Zero-block command.
      new_test(32'h0, 32'd0);
      @(negedge CLK);
      START = 1'b1; BASE_ADR = 32'h80; NBLOCKS = 32'd0;
      @(negedge CLK);
      START = 1'b0;
      check_val("t2_busy_c1", 128'(BUSY), 128'(1));
      check_val("t2_done_c1", 128'(DONE), 128'(0));
      @(negedge CLK);
      check_val("t2_busy_c2", 128'(BUSY), 128'(0));
      check_val("t2_done_c2", 128'(DONE), 128'(1));
      @(negedge CLK);
      check_val("t2_done_c3", 128'(DONE), 128'(0));
      repeat (3) @(negedge CLK);
      check_val("t2_nreq", 128'(req_a.size()), 128'(0));

      // Backpressure: FIFO fills after two bursts, third issues once room frees up.
      O_READY = 1'b0;
      new_test(32'h200, 32'd12);
      do_start(32'h200, 32'd12);
      repeat (40) @(negedge CLK);
      check_val("t3_nreq_stalled", 128'(req_a.size()), 128'(2));
      check_val("t3_valid_held", 128'(O_VALID), 128'(1));
      check_val("t3_data_held", O_DATA, beat(32'h200, 0));
      check_val("t3_busy", 128'(BUSY), 128'(1));
      @(posedge CLK);
      #1 O_READY = 1'b1;
      wait_done(600);
      check_val("t3_nreq", 128'(req_a.size()), 128'(3));
      check_req(2, 32'h240, 32'd4);
      check_val("t3_beats", 128'(beats_seen), 128'(48));
      check_val("t3_err", 128'(ERR), 128'(0));

      // Address wrap-around at LAST_ADDR.
      new_test(LAST - 32'd8, 32'd4);
      do_start(LAST - 32'd8, 32'd4);
      wait_done(400);
      check_val("t4a_nreq", 128'(req_a.size()), 128'(1));
      check_req(0, LAST - 32'd8, 32'd4);
      check_val("t4a_beats", 128'(beats_seen), 128'(16));
      new_test(LAST, 32'd6);
      do_start(LAST, 32'd6);
      wait_done(400);
      check_val("t4b_nreq", 128'(req_a.size()), 128'(2));
      check_req(0, LAST, 32'd4);
      check_req(1, 32'h18, 32'd2);
      check_val("t4b_beats", 128'(beats_seen), 128'(24));
      check_val("t4_err", 128'(ERR), 128'(0));

      // Protocol errors: stray data while idle, then START while busy.
      @(negedge CLK);
      inj_en = 1'b1;
      @(negedge CLK);
      inj_en = 1'b0;
      check_val("t5_err_stray", 128'(ERR), 128'(1));
      repeat (3) @(negedge CLK);
      check_val("t5_err_sticky", 128'(ERR), 128'(1));
      check_val("t5_no_beat", 128'(O_VALID), 128'(0));
      RST_X = 1'b0;
      repeat (2) @(negedge CLK);
      RST_X = 1'b1;
      check_val("t5_err_cleared", 128'(ERR), 128'(0));
      new_test(32'h300, 32'd8);
      do_start(32'h300, 32'd8);
      repeat (5) @(negedge CLK);
      check_val("t5_err_before", 128'(ERR), 128'(0));
      do_start(32'hDEAD_0000, 32'd5);
      check_val("t5_err_start_busy", 128'(ERR), 128'(1));
      wait_done(400);
      check_val("t5_nreq", 128'(req_a.size()), 128'(2));
      check_req(0, 32'h300, 32'd4);
      check_req(1, 32'h320, 32'd4);
      check_val("t5_beats", 128'(beats_seen), 128'(32));
      check_val("t5_err_end", 128'(ERR), 128'(1));

      // Reset while a burst is outstanding.
      RST_X = 1'b0;
      repeat (2) @(negedge CLK);
      RST_X = 1'b1;
      new_test(32'h400, 32'd8);
      do_start(32'h400, 32'd8);
      c = 0;
      while (D_REQ != 2'd2 && c < 50) begin
         @(negedge CLK);
         c++;
      end
      check_val("t6_req_seen", 128'(D_REQ), 128'(2));
      #2 RST_X = 1'b0;
      #1;
      check_val("t6_async_d_req", 128'(D_REQ), 128'(0));
      check_val("t6_async_busy", 128'(BUSY), 128'(0));
      check_val("t6_async_initadr", 128'(D_INITADR), 128'(0));
      check_val("t6_async_err", 128'(ERR), 128'(0));
      exp_q.delete();
      @(negedge CLK);
      @(negedge CLK);
      RST_X = 1'b1;
      repeat (4) @(negedge CLK);
      check_val("t6_inflight_err", 128'(ERR), 128'(1));
      check_val("t6_idle_valid", 128'(O_VALID), 128'(0));
      check_val("t6_idle_busy", 128'(BUSY), 128'(0));
      new_test(32'h500, 32'd4);
      do_start(32'h500, 32'd4);
      wait_done(400);
      check_val("t6_nreq", 128'(req_a.size()), 128'(1));
      check_req(0, 32'h500, 32'd4);
      check_val("t6_beats", 128'(beats_seen), 128'(16));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
